// File: rtl/npc_pkg.sv
// npc_pkg: shared constants and types for the next-PC predictor.
// BTB geometry defaults, 2-bit counter encodings, counter reset/allocate
// values and the sequential fetch increment.
package npc_pkg;

  localparam int NPC_BTB_ENTRIES_DEF = 16;
  localparam int NPC_TAG_W_DEF       = 10;

  // Two-bit direction counter encodings; bit 1 is the taken prediction.
  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } npc_ctr_e;

  localparam npc_ctr_e NPC_CTR_RESET = CTR_WNT;
  localparam npc_ctr_e NPC_CTR_ALLOC = CTR_WT;

  localparam logic [63:0] NPC_FETCH_INC = 64'd4;

endpackage : npc_pkg

// File: rtl/npc_sat_ctr.sv
// npc_sat_ctr: 2-bit saturating direction counter for one BTB entry.
// load_i has priority over inc_i/dec_i; inc and dec saturate at ST/SNT.
module npc_sat_ctr
  import npc_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic       load_i,
  input  logic [1:0] load_val_i,
  output logic [1:0] ctr_o
);

  logic [1:0] ctr_q;
  logic [1:0] ctr_d;

  // Next counter value: load wins, otherwise saturating step.
  always_comb begin
    ctr_d = ctr_q;
    if (load_i) begin
      ctr_d = load_val_i;
    end else if (inc_i) begin
      if (ctr_q != CTR_ST) ctr_d = ctr_q + 2'd1;
    end else if (dec_i) begin
      if (ctr_q != CTR_SNT) ctr_d = ctr_q - 2'd1;
    end
  end

  // Counter register, reset to weakly-not-taken.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) ctr_q <= NPC_CTR_RESET;
    else          ctr_q <= ctr_d;
  end

  assign ctr_o = ctr_q;

endmodule : npc_sat_ctr

// File: rtl/npc_pred.sv
// npc_pred: direct-mapped BTB next-PC predictor.
// Lookup is a zero-latency combinational read at pc_s0_i; training comes
// from retired control transfers and is written at the clock edge.
// Optional feature macro NPC_BTB_CTR_EN: per-entry 2-bit direction
// counters (npc_sat_ctr). Without it every hit predicts taken and a
// not-taken hit evicts the entry.
//
// Update strobe: upd_vld_rt_i is a single-cycle qualifier with no
// back-pressure; the update fields are sampled on every rising edge where
// it is high, and the predictor always accepts it (inval_all_i or reset
// drops it).
module npc_pred
  import npc_pkg::*;
#(
  parameter int BTB_ENTRIES = NPC_BTB_ENTRIES_DEF,
  parameter int TAG_W       = NPC_TAG_W_DEF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [63:0] pc_s0_i,
  input  logic        upd_vld_rt_i,
  input  logic [63:0] upd_pc_rt_i,
  input  logic [63:0] upd_tgt_rt_i,
  input  logic        upd_taken_rt_i,
  input  logic        inval_all_i,
  output logic [63:0] branch_pc_f0_o,
  output logic        pred_taken_f0_o,
  output logic        btb_hit_f0_o
);

  localparam int IDX_W  = $clog2(BTB_ENTRIES);
  localparam int TAG_LO = IDX_W + 2;
  localparam int TAG_HI = IDX_W + 1 + TAG_W;

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [BTB_ENTRIES-1:0] valid_d;
  logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
  logic [63:0]            tgt_q [BTB_ENTRIES];

  logic [IDX_W-1:0] l_idx;
  logic [TAG_W-1:0] l_tag;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic             upd_ok;
  logic             alloc_en;
  logic             hit_upd_en;
  logic             tgt_we;
  logic             unused_pc_bits;

  // PC bits outside the index/tag fields do not take part in the lookup.
  assign unused_pc_bits = ^{pc_s0_i[63:TAG_HI+1], pc_s0_i[1:0],
                            upd_pc_rt_i[63:TAG_HI+1], upd_pc_rt_i[1:0]};

  assign l_idx = pc_s0_i[IDX_W+1:2];
  assign l_tag = pc_s0_i[TAG_HI:TAG_LO];
  assign u_idx = upd_pc_rt_i[IDX_W+1:2];
  assign u_tag = upd_pc_rt_i[TAG_HI:TAG_LO];

  assign btb_hit_f0_o = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign u_hit        = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  // Invalidate-all and reset both swallow a same-cycle update.
  assign upd_ok     = upd_vld_rt_i && !inval_all_i && reset_n;
  assign alloc_en   = upd_ok && !u_hit && upd_taken_rt_i;
  assign hit_upd_en = upd_ok && u_hit;
  assign tgt_we     = alloc_en || (hit_upd_en && upd_taken_rt_i);

`ifdef NPC_BTB_CTR_EN
  logic [1:0] ctr_q [BTB_ENTRIES];

  for (genvar i = 0; i < BTB_ENTRIES; i++) begin : g_ctr
    localparam logic [IDX_W-1:0] ENT_IDX = IDX_W'(i);
    logic sel;
    assign sel = (u_idx == ENT_IDX);

    npc_sat_ctr u_ctr (
      .clk_i      (clock),
      .rst_n_i    (reset_n),
      .inc_i      (hit_upd_en && upd_taken_rt_i && sel),
      .dec_i      (hit_upd_en && !upd_taken_rt_i && sel),
      .load_i     (alloc_en && sel),
      .load_val_i (NPC_CTR_ALLOC),
      .ctr_o      (ctr_q[i])
    );
  end

  assign pred_taken_f0_o = btb_hit_f0_o && ctr_q[l_idx][1];
`else
  assign pred_taken_f0_o = btb_hit_f0_o;
`endif

  assign branch_pc_f0_o = pred_taken_f0_o ? tgt_q[l_idx]
                                          : (pc_s0_i + NPC_FETCH_INC);

  // Next valid bits: flash-clear, allocation, and (counterless) eviction.
  always_comb begin
    valid_d = valid_q;
    if (inval_all_i) begin
      valid_d = '0;
    end else begin
      if (alloc_en) valid_d[u_idx] = 1'b1;
`ifndef NPC_BTB_CTR_EN
      if (hit_upd_en && !upd_taken_rt_i) valid_d[u_idx] = 1'b0;
`endif
    end
  end

  // Valid bits: the only table state that needs a reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) valid_q <= '0;
    else          valid_q <= valid_d;
  end

  // Tag and target arrays: written on allocation / taken hit, no reset.
  always_ff @(posedge clock) begin
    if (alloc_en) tag_q[u_idx] <= u_tag;
    if (tgt_we)   tgt_q[u_idx] <= upd_tgt_rt_i;
  end

endmodule : npc_pred

// File: tb/tb_npc_pred.sv
// tb_npc_pred: directed bench for npc_pred with hand-computed expectations.
// Expectations for NPC_BTB_CTR_EN builds follow the counter behaviour;
// default builds follow the counterless evict-on-not-taken behaviour.
module tb_npc_pred;

  logic        clock;
  logic        reset_n;
  logic [63:0] pc_s0_i;
  logic        upd_vld_rt_i;
  logic [63:0] upd_pc_rt_i;
  logic [63:0] upd_tgt_rt_i;
  logic        upd_taken_rt_i;
  logic        inval_all_i;
  logic [63:0] branch_pc_f0_o;
  logic        pred_taken_f0_o;
  logic        btb_hit_f0_o;

  int total;
  int bad;
  logic [63:0] exp_q[$];

  npc_pred dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .pc_s0_i         (pc_s0_i),
    .upd_vld_rt_i    (upd_vld_rt_i),
    .upd_pc_rt_i     (upd_pc_rt_i),
    .upd_tgt_rt_i    (upd_tgt_rt_i),
    .upd_taken_rt_i  (upd_taken_rt_i),
    .inval_all_i     (inval_all_i),
    .branch_pc_f0_o  (branch_pc_f0_o),
    .pred_taken_f0_o (pred_taken_f0_o),
    .btb_hit_f0_o    (btb_hit_f0_o)
  );

  // Clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Compare current outputs against the three expected values queued.
  task automatic score(input string tag);
    logic [63:0] e;
    e = exp_q.pop_front(); check({tag, ".hit"},   {63'd0, btb_hit_f0_o},    e);
    e = exp_q.pop_front(); check({tag, ".taken"}, {63'd0, pred_taken_f0_o}, e);
    e = exp_q.pop_front(); check({tag, ".npc"},   branch_pc_f0_o,           e);
  endtask

  // Driver tasks
  task automatic lookup(input string tag, input logic [63:0] pc,
                        input logic hit, input logic tk, input logic [63:0] npc);
    @(negedge clock);
    pc_s0_i = pc;
    exp_q.push_back({63'd0, hit});
    exp_q.push_back({63'd0, tk});
    exp_q.push_back(npc);
    #1;
    score(tag);
  endtask

  task automatic update(input logic [63:0] pc, input logic [63:0] tgt,
                        input logic taken, input logic inval);
    @(negedge clock);
    upd_vld_rt_i   = 1'b1;
    upd_pc_rt_i    = pc;
    upd_tgt_rt_i   = tgt;
    upd_taken_rt_i = taken;
    inval_all_i    = inval;
    @(posedge clock);
    #1;
    upd_vld_rt_i   = 1'b0;
    upd_taken_rt_i = 1'b0;
    inval_all_i    = 1'b0;
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    reset_n        = 1'b0;
    pc_s0_i        = 64'h0;
    upd_vld_rt_i   = 1'b0;
    upd_pc_rt_i    = 64'h0;
    upd_tgt_rt_i   = 64'h0;
    upd_taken_rt_i = 1'b0;
    inval_all_i    = 1'b0;

    // Update attempted while in reset must be ignored.
    update(64'h1000, 64'h9000, 1'b1, 1'b0);
    lookup("in_reset", 64'h1000, 1'b0, 1'b0, 64'h1004);
    @(negedge clock);
    reset_n = 1'b1;

    lookup("post_reset", 64'h1000, 1'b0, 1'b0, 64'h1004);

    // Allocate 0x1000 -> 0x2000; same-cycle lookup still sees old contents.
    @(negedge clock);
    upd_vld_rt_i   = 1'b1;
    upd_pc_rt_i    = 64'h1000;
    upd_tgt_rt_i   = 64'h2000;
    upd_taken_rt_i = 1'b1;
    pc_s0_i        = 64'h1000;
    exp_q.push_back(64'd0); exp_q.push_back(64'd0); exp_q.push_back(64'h1004);
    #1;
    score("same_cycle");
    @(posedge clock);
    #1;
    upd_vld_rt_i   = 1'b0;
    upd_taken_rt_i = 1'b0;
    lookup("alloc", 64'h1000, 1'b1, 1'b1, 64'h2000);

    // Not-taken training on the allocated entry.
    update(64'h1000, 64'h0, 1'b0, 1'b0);
`ifdef NPC_BTB_CTR_EN
    lookup("nt1", 64'h1000, 1'b1, 1'b0, 64'h1004);
    update(64'h1000, 64'h0, 1'b0, 1'b0);
    lookup("nt2", 64'h1000, 1'b1, 1'b0, 64'h1004);
    update(64'h1000, 64'h0, 1'b0, 1'b0);
    update(64'h1000, 64'h2400, 1'b1, 1'b0);
    lookup("sat_lo", 64'h1000, 1'b1, 1'b0, 64'h1004);
    update(64'h1000, 64'h2400, 1'b1, 1'b0);
    lookup("retrain", 64'h1000, 1'b1, 1'b1, 64'h2400);
`else
    lookup("nt_evict", 64'h1000, 1'b0, 1'b0, 64'h1004);
    update(64'h1000, 64'h0, 1'b0, 1'b0);
    lookup("nt_miss", 64'h1000, 1'b0, 1'b0, 64'h1004);
    update(64'h1000, 64'h2400, 1'b1, 1'b0);
    lookup("realloc", 64'h1000, 1'b1, 1'b1, 64'h2400);
`endif

    // Alias with same index, different tag overwrites the victim.
    update(64'h1040, 64'h3000, 1'b1, 1'b0);
    lookup("alias_old", 64'h1000, 1'b0, 1'b0, 64'h1004);
    lookup("alias_new", 64'h1040, 1'b1, 1'b1, 64'h3000);

    // Upper saturation: 10 -> 11 -> 11, then one not-taken.
    update(64'h1040, 64'h3000, 1'b1, 1'b0);
    update(64'h1040, 64'h3000, 1'b1, 1'b0);
    update(64'h1040, 64'h3000, 1'b0, 1'b0);
`ifdef NPC_BTB_CTR_EN
    lookup("sat_hi", 64'h1040, 1'b1, 1'b1, 64'h3000);
    update(64'h1040, 64'h3000, 1'b0, 1'b0);
    lookup("sat_hi_dn", 64'h1040, 1'b1, 1'b0, 64'h1044);
`else
    lookup("hit_nt_evict", 64'h1040, 1'b0, 1'b0, 64'h1044);
`endif

    // Not-taken miss leaves the table unchanged.
    update(64'h1008, 64'h7000, 1'b0, 1'b0);
    lookup("nt_miss_noalloc", 64'h1008, 1'b0, 1'b0, 64'h100C);

    // Allocate another index, then invalidate together with an update.
    update(64'h1008, 64'h5000, 1'b1, 1'b0);
    lookup("alloc_idx2", 64'h1008, 1'b1, 1'b1, 64'h5000);
    update(64'h100C, 64'h6000, 1'b1, 1'b1);
    lookup("inval_a", 64'h1008, 1'b0, 1'b0, 64'h100C);
    lookup("inval_b", 64'h100C, 1'b0, 1'b0, 64'h1010);
    lookup("wrap", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 64'h0);

    // Reset mid-operation discards learned state.
    update(64'h1010, 64'h8000, 1'b1, 1'b0);
    lookup("pre_rst", 64'h1010, 1'b1, 1'b1, 64'h8000);
    @(negedge clock);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    lookup("mid_rst", 64'h1010, 1'b0, 1'b0, 64'h1014);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_npc_pred
